// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage responder for execute-stage loads and stores.
// Drives one outstanding data-memory access at a time, places store bytes on
// the right lanes, and aligns plus sign/zero-extends load data for write-back.
module load_store_unit #(
  parameter int unsigned RVALID_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic [3:0]  ls_type,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [4:0]  ls_rd,
  output logic        busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] mem_rd_val,
  output logic        ls_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  // Counter only needs to reach RVALID_TIMEOUT-1; the expiring cycle is
  // detected by comparison rather than by counting past it.
  localparam int unsigned CW = (RVALID_TIMEOUT < 2) ? 1 : $clog2(RVALID_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(RVALID_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   baddr_q, baddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   raddr_q, raddr_d;   // full request address, kept for lanes and faults
  logic [1:0]    size_q, size_d;     // 0 byte, 1 half, 2 word
  logic          uns_q, uns_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [31:0]   mem_rd_val_q, mem_rd_val_d;
  logic          fault_q, fault_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   fault_addr_q, fault_addr_d;

  logic          in_legal, in_misaligned, in_uns;
  logic [1:0]    in_size;
  logic [3:0]    in_be;
  logic [31:0]   in_wdata;
  logic [31:0]   shifted, load_data;

  // Decode the incoming request: legality, size, alignment and lane mapping.
  always_comb begin
    in_legal = 1'b1;
    in_size  = 2'd0;
    in_uns   = 1'b0;
    case (ls_type[2:0])
      3'b000:  in_size = 2'd0;
      3'b001:  in_size = 2'd1;
      3'b010:  in_size = 2'd2;
      3'b100:  begin in_size = 2'd0; in_uns = 1'b1; in_legal = ~ls_type[3]; end
      3'b110:  begin in_size = 2'd1; in_uns = 1'b1; in_legal = ~ls_type[3]; end
      default: in_legal = 1'b0;
    endcase
    in_misaligned = ((in_size == 2'd1) && ls_addr[0]) ||
                    ((in_size == 2'd2) && (ls_addr[1:0] != 2'b00));
    case (in_size)
      2'd0:    begin in_be = 4'(4'b0001 << ls_addr[1:0]); in_wdata = {4{ls_wdata[7:0]}}; end
      2'd1:    begin in_be = ls_addr[1] ? 4'b1100 : 4'b0011; in_wdata = {2{ls_wdata[15:0]}}; end
      default: begin in_be = 4'b1111; in_wdata = ls_wdata; end
    endcase
  end

  // Align the returned word to the request offset and extend to 32 bits.
  always_comb begin
    shifted = dmem_rdata >> {raddr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Next-state and next-output computation for the IDLE/REQ/WAIT sequencer.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    be_d         = be_q;
    baddr_d      = baddr_q;
    wdata_d      = wdata_q;
    raddr_d      = raddr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    mem_rd_val_d = mem_rd_val_q;
    fault_d      = 1'b0;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          if (!in_legal || in_misaligned) begin
            // Rejected at the door: no bus activity, just a fault pulse.
            fault_d      = 1'b1;
            cause_d      = !in_legal ? 2'b10 : 2'b01;
            fault_addr_d = ls_addr;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = ls_type[3];
            be_d    = in_be;
            baddr_d = {ls_addr[31:2], 2'b00};
            wdata_d = in_wdata;
            raddr_d = ls_addr;
            size_d  = in_size;
            uns_d   = in_uns;
            rd_d    = ls_rd;
          end
        end
      end
      ST_REQ: begin
        // Bus fields stay frozen until the grant; rvalid is ignored here.
        if (dmem_gnt) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = we_q ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_d = ST_IDLE;
          if (rd_q != 5'd0) begin
            wb_valid_d   = 1'b1;
            wb_rd_d      = rd_q;
            wb_data_d    = load_data;
            mem_rd_val_d = load_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          fault_d      = 1'b1;
          cause_d      = 2'b11;
          fault_addr_d = raddr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      baddr_q      <= '0;
      wdata_q      <= '0;
      raddr_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      cnt_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      mem_rd_val_q <= '0;
      fault_q      <= 1'b0;
      cause_q      <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      be_q         <= be_d;
      baddr_q      <= baddr_d;
      wdata_q      <= wdata_d;
      raddr_q      <= raddr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      mem_rd_val_q <= mem_rd_val_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign ls_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_be     = be_q;
  assign dmem_addr   = baddr_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign mem_rd_val  = mem_rd_val_q;
  assign ls_fault    = fault_q;
  assign fault_cause = cause_q;
  assign fault_addr  = fault_addr_q;

endmodule
